imm_gen_stage: RTL

- Registered, flow-controlled immediate generator for the decode stage.
- Generalises the combinational immediate extender in three ways:
  - XLEN-parametrised (RV32/RV64) sign extension.
  - Adds the CSR zimm (Z) format, a format tag and an illegal-encoding flag.
  - Adds a valid/ready handshake with a 2-entry skid buffer and a synchronous flush.
- Sits between the fetch queue and the register-read stage.

---
 rtl/imm_pkg.sv | 38 +++
 rtl/imm_decode.sv | 77 +++++++
 rtl/imm_gen_stage.sv | 78 +++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared encodings for the decode-stage immediate generator: format tags,
// RISC-V major opcodes and the decoded-entry record held in the pipeline.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6
  } fmt_t;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  // imm is the 32-bit form; every format's value is already sign-correct at
  // bit 31, so widening to XLEN only needs to replicate imm[31].
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    fmt_t        fmt;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder. XLEN/RV64_OPS decide whether the RV64
// word-sized opcodes are legal; the immediate is produced in 32-bit form.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit RV64_OPS = 1'b1
) (
  input  logic [31:0] instr,
  output entry_t      dec
);

  localparam bit W64_OK = (XLEN == 64) && RV64_OPS;

  logic [6:0]  opcode;
  logic        sgn;
  logic [31:0] imm_i;

  assign opcode = instr[6:0];
  assign sgn    = instr[31];
  assign imm_i  = {{20{sgn}}, instr[31:20]};

  always_comb begin
    dec.instr   = instr;
    dec.imm     = '0;
    dec.fmt     = FMT_R;
    dec.illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_FENCE: begin
          dec.fmt = FMT_I;
          dec.imm = imm_i;
        end
        OPC_SYSTEM: begin
          // funct3[2] selects the CSR immediate forms (zimm in the rs1 field)
          if (instr[14]) begin
            dec.fmt = FMT_Z;
            dec.imm = {27'd0, instr[19:15]};
          end else begin
            dec.fmt = FMT_I;
            dec.imm = imm_i;
          end
        end
        OPC_OPIMM32: begin
          if (W64_OK) begin
            dec.fmt = FMT_I;
            dec.imm = imm_i;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OPC_STORE: begin
          dec.fmt = FMT_S;
          dec.imm = {{20{sgn}}, instr[31:25], instr[11:7]};
        end
        OPC_BRANCH: begin
          dec.fmt = FMT_B;
          dec.imm = {{19{sgn}}, sgn, instr[7], instr[30:25], instr[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          dec.fmt = FMT_U;
          dec.imm = {instr[31:12], 12'h000};
        end
        OPC_JAL: begin
          dec.fmt = FMT_J;
          dec.imm = {{11{sgn}}, sgn, instr[19:12], instr[20], instr[30:21], 1'b0};
        end
        OPC_OP: dec.fmt = FMT_R;
        OPC_OP32: dec.illegal = !W64_OK;
        default: dec.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with valid/ready flow control: one output
// register plus one skid entry, synchronous flush and reset.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit RV64_OPS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  entry_t dec;
  entry_t out_q;
  entry_t skid_q;
  logic   skid_valid;

  imm_decode #(
    .XLEN     (XLEN),
    .RV64_OPS (RV64_OPS)
  ) u_decode (
    .instr (in_instr),
    .dec   (dec)
  );

  assign in_ready = !skid_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Output register is free this cycle; the skid entry is older than
      // anything on the input, so it always refills first.
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_q <= dec;
      end
    end else if (in_valid && !skid_valid) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_instr   = out_q.instr;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;

  if (XLEN == 64) begin : g_ext64
    assign out_imm = {{32{out_q.imm[31]}}, out_q.imm};
  end else begin : g_ext32
    assign out_imm = out_q.imm;
  end

endmodule
